// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between Icache and Dcache, tracks load tags and routes returns.
// Define MEM_ARB_ANTI_STARVE_EN to let a starved Icache win after STARVE_LIMIT denied cycles.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Imem_command,
    input  logic [63:0] proc2Imem_addr,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [63:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  Imem2proc_response,
    output logic [3:0]  Dmem2proc_response,
    output logic [3:0]  Imem2proc_tag,
    output logic [3:0]  Dmem2proc_tag,
    output logic [4:0]  outstanding_cnt,
    output logic        spurious_tag
);
    localparam logic [1:0] CMD_LOAD = 2'd1;

    logic [15:0] valid_q, valid_d, owner_q, owner_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        spur_q, spur_d;
    logic        i_act, d_act, i_prio, grant_i, grant_d, hit, alloc;

    assign i_act   = proc2Imem_command != 2'd0;
    assign d_act   = proc2Dmem_command != 2'd0;
    assign grant_d = d_act && !(i_act && i_prio);
    assign grant_i = i_act && !grant_d;

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign i_prio = starve_q == SW'(STARVE_LIMIT);
    always_comb starve_d = (i_act && !grant_i) ? (i_prio ? starve_q : starve_q + 1'b1) : '0;
    always_ff @(posedge clock or negedge reset)
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
`else
    assign i_prio = 1'b0;
`endif

    always_comb begin
        proc2mem_command   = grant_d ? proc2Dmem_command : grant_i ? proc2Imem_command : 2'd0;
        proc2mem_addr      = grant_d ? proc2Dmem_addr : grant_i ? proc2Imem_addr : 64'd0;
        proc2mem_data      = grant_d ? proc2Dmem_data : 64'd0;
        Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
        Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;
    end

    assign hit           = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    assign alloc         = (proc2mem_command == CMD_LOAD) && (mem2proc_response != 4'd0);
    assign Imem2proc_tag = (hit && !owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign Dmem2proc_tag = (hit && owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;

    // Return is retired before allocation so a same-cycle reuse of the tag is not a conflict.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        spur_d  = (mem2proc_tag != 4'd0) && !hit;
        if (hit) valid_d[mem2proc_tag] = 1'b0;
        if (alloc) begin
            spur_d = spur_d | valid_d[mem2proc_response];
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant_d;
        end
        cnt_d = '0;
        for (int k = 0; k < 16; k++) cnt_d = cnt_d + 5'(valid_d[k]);
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            valid_q <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            spur_q  <= spur_d;
        end

    assign outstanding_cnt = cnt_q;
    assign spurious_tag    = spur_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, number of consecutive denied Icache load cycles before the Icache takes priority.
REQ-002 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: proc2Imem_command  in  2  Icache request (0 NONE, 1 LOAD, 2 STORE, 3 reserved).
REQ-005 SHALL have ports: proc2Imem_addr  in  64  Icache address.
REQ-006 SHALL have ports: proc2Dmem_command  in  2  Dcache request, same encoding.
REQ-007 SHALL have ports: proc2Dmem_addr  in  64  Dcache address.
REQ-008 SHALL have ports: proc2Dmem_data  in  64  Dcache store data.
REQ-009 SHALL have ports: mem2proc_response  in  4  memory accept tag for this cycle's command, 0 = rejected.
REQ-010 SHALL have ports: mem2proc_tag  in  4  tag of the returning load data, 0 = none.
REQ-011 SHALL have ports: proc2mem_command  out  2  granted command to memory.
REQ-012 SHALL have ports: proc2mem_addr  out  64  granted address.
REQ-013 SHALL have ports: proc2mem_data  out  64  store data (Dcache data when Dcache is granted, else 0).
REQ-014 SHALL have ports: Imem2proc_response, Dmem2proc_response  out  4 each  accept tag, routed to the granted requester only.
REQ-015 SHALL have ports: Imem2proc_tag, Dmem2proc_tag  out  4 each  return tag, routed to the owner only.
REQ-016 SHALL have ports: outstanding_cnt  out  5  number of valid owner-table entries.
REQ-017 SHALL have ports: spurious_tag  out  1  registered one-cycle pulse on a return with no matching owner.

Function
REQ-018 SHALL grant combinationally within the same cycle; a requester is active when its command is not NONE.
REQ-019 SHALL grant the Dcache when both requesters are active, except as modified by REQ-030.
REQ-020 SHALL drive NONE, address 0 and data 0 to memory when no requester is active.
REQ-021 SHALL drive the non-granted requester's response to 0 (rejected) so that requester retries; the granted requester SHALL receive mem2proc_response unchanged.
REQ-022 SHALL hold a 16-entry owner table (entry 0 unused), each entry a valid bit plus an owner bit (I/D).
REQ-023 SHALL, on the clock edge after a granted LOAD receives a nonzero response R, set entry R valid with the grantee as owner; STOREs SHALL NOT allocate.
REQ-024 SHALL, when mem2proc_tag T is nonzero and entry T is valid, drive T to the owner's tag output and 0 to the other, and clear entry T on the next edge.
REQ-025 SHALL drive both tag outputs to 0 when T is 0 or entry T is invalid; an invalid nonzero T SHALL pulse spurious_tag on the next cycle.
REQ-026 SHALL, when the same cycle both returns T and accepts a new LOAD with response T, let the allocation win: the entry remains valid with the new owner.
REQ-027 SHALL, on allocation to an already-valid entry, overwrite it and pulse spurious_tag.
REQ-028 SHALL update outstanding_cnt as a registered count consistent with the table after each edge (range 0..15).

Reset
REQ-029 SHALL, on reset low at any time: clear all owner-table entries, zero outstanding_cnt, spurious_tag and the starvation counter immediately; combinational outputs then follow REQ-018..021 with an empty table.

Configuration
REQ-030 SHALL, with macro MEM_ARB_ANTI_STARVE_EN defined, count consecutive cycles in which the Icache is active but denied (counter saturates at STARVE_LIMIT, resets to 0 on any Icache grant or inactive cycle); while the counter equals STARVE_LIMIT, the Icache SHALL win contention. Without the macro, the counter SHALL NOT exist and the Dcache SHALL always win.

Verification
REQ-031 SHALL cover: only Icache LOAD addr 0x100, mem response 3 -> proc2mem_addr 0x100, Imem2proc_response 3, Dmem2proc_response 0, outstanding_cnt 1 next cycle.
REQ-032 SHALL cover: both LOAD in one cycle, response 5 -> Dcache granted, Dmem2proc_response 5, Imem2proc_response 0; later mem2proc_tag 5 -> Dmem2proc_tag 5, Imem2proc_tag 0, entry cleared.
REQ-033 SHALL cover: with MEM_ARB_ANTI_STARVE_EN and STARVE_LIMIT 4, both active continuously -> Dcache granted cycles 0-3, Icache granted cycle 4; without the macro, Dcache granted every cycle.
REQ-034 SHALL cover: mem2proc_tag 7 with entry 7 invalid -> both tag outputs 0 and spurious_tag 1 for exactly one cycle.
REQ-035 SHALL cover: Icache owns tag 2, same cycle returns tag 2 and Dcache LOAD accepted with response 2 -> Imem2proc_tag 2 this cycle, entry 2 owned by the Dcache afterwards, outstanding_cnt unchanged.
REQ-036 SHALL cover: reset asserted with 3 entries outstanding -> outstanding_cnt 0 without waiting for a clock edge; a later tag return produces spurious_tag.
